hpretl_tt03_temp_sensor: RTL and testbench



---
 rtl/hpretl_tt03_temp_sensor_if.sv | 9 +
 rtl/hpretl_tt03_temp_sensor.sv | 162 ++++++++++++++++
 tb/tb_hpretl_tt03_temp_sensor.sv | 139 +++++++++++++
 3 files changed

// File: rtl/hpretl_tt03_temp_sensor_if.sv
// Tile pin bundle for the temperature sensor: the 8 tile inputs and 8 tile outputs.
// The sensor itself drives the slave side; a test harness or pad ring drives the master side.
interface hpretl_tt03_temp_sensor_if;
  logic [7:0] io_in;
  logic [7:0] io_out;

  modport master (output io_in, input io_out);
  modport slave  (input io_in, output io_out);
endinterface

// File: rtl/hpretl_tt03_temp_sensor.sv
// Delay-based temperature sensor with serial offset/gain calibration and a 2-digit 7-segment readout.
// Define TEMPSENS_SIM_MODEL_EN to replace the inverter-chain sensor cell with a 40-cycle behavioural model.
module hpretl_tt03_temp_sensor (
  hpretl_tt03_temp_sensor_if.slave tile
);
  localparam logic [9:0]  CNT_MAX   = 10'd1023;
  localparam logic [3:0]  DSCHG_END = 4'd15;
  localparam logic [15:0] CAL_RST   = 16'h0010;

  typedef enum logic [1:0] {IDLE, CHARGE, LATCH, DISCHARGE} state_t;

  logic       clk, rst_n, cal_clk, cal_dat, cal_ena;
  logic [2:0] dbg;
  assign clk     = tile.io_in[0];
  assign rst_n   = tile.io_in[1];
  assign cal_clk = tile.io_in[2];
  assign cal_dat = tile.io_in[3];
  assign cal_ena = tile.io_in[4];
  assign dbg     = tile.io_in[7:5];

  state_t      state, state_nxt;
  logic        start, done_raw, done_s;
  logic [1:0]  done_sync;
  logic [9:0]  cnt;
  logic [7:0]  raw;
  logic [3:0]  dis_cnt;
  logic [6:0]  temp, temp_nxt;
  logic [15:0] cal;
  logic [2:0]  cal_clk_sync;
  logic [11:0] presc;
  logic        dig_sel;

  function automatic logic [6:0] sat_temp(input logic [15:0] p);
    logic [15:0] q;
    q = p >> 4;
    return (q > 16'd99) ? 7'd99 : q[6:0];
  endfunction

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [3:0] tens, units;
    tens = '0;
    for (int t = 1; t <= 9; t++)
      if (v >= 7'(10 * t)) tens = 4'(t);
    // units < 10, so modulo-16 arithmetic recovers it exactly
    units = v[3:0] - tens * 4'd10;
    return {tens, units};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

`ifdef TEMPSENS_SIM_MODEL_EN
  logic [5:0] dly;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly      <= '0;
      done_raw <= 1'b0;
    end else if (start) begin
      if (dly != 6'd40) dly <= dly + 6'd1;
      done_raw <= (dly >= 6'd39);
    end else begin
      dly      <= '0;
      done_raw <= 1'b0;
    end
  end
`else
  (* keep = "true", dont_touch = "true" *) logic [128:0] chain;
  assign chain[0] = start;
  for (genvar i = 0; i < 128; i++) begin : g_inv
    assign chain[i+1] = ~chain[i];
  end
  assign done_raw = chain[128];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_sync    <= '0;
      cal_clk_sync <= '0;
      cal          <= CAL_RST;
      presc        <= '0;
      dig_sel      <= 1'b0;
    end else begin
      done_sync    <= {done_sync[0], done_raw};
      cal_clk_sync <= {cal_clk_sync[1:0], cal_clk};
      if (cal_clk_sync[1] && !cal_clk_sync[2]) cal <= {cal[14:0], cal_dat};
      presc <= presc + 12'd1;
      if (presc == 12'hFFF) dig_sel <= ~dig_sel;
    end
  end
  assign done_s = done_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE:      state_nxt = CHARGE;
      CHARGE: begin
        start = 1'b1;
        if (done_s || cnt == CNT_MAX) state_nxt = LATCH;
      end
      LATCH:     state_nxt = DISCHARGE;
      DISCHARGE: if (dis_cnt == DSCHG_END && !done_s) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Conversion: offset subtract with floor at zero, then Q2.4 gain and clamp to 99
  logic [9:0]  offset, diff;
  logic [5:0]  gain;
  logic [15:0] prod;
  assign offset   = cal_ena ? cal[15:6] : 10'd0;
  assign gain     = cal_ena ? cal[5:0]  : 6'd16;
  assign diff     = (cnt < offset) ? 10'd0 : cnt - offset;
  assign prod     = {6'd0, diff} * {10'd0, gain};
  assign temp_nxt = sat_temp(prod);

  // Only the low byte of the raw count is ever displayed, so only that is kept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      raw     <= '0;
      temp    <= '0;
      dis_cnt <= '0;
    end else begin
      case (state)
        IDLE:   cnt <= '0;
        CHARGE: if (!done_s && cnt != CNT_MAX) cnt <= cnt + 10'd1;
        LATCH: begin
          raw     <= cnt[7:0];
          temp    <= temp_nxt;
          dis_cnt <= '0;
        end
        DISCHARGE: if (dis_cnt != DSCHG_END) dis_cnt <= dis_cnt + 4'd1;
        default: ;
      endcase
    end
  end

  logic [7:0] pair;
  logic [3:0] nib;
  always_comb begin
    case (dbg)
      3'b011:  pair = raw;
      3'b001:  pair = cal[7:0];
      default: pair = to_bcd(temp);
    endcase
    nib = dig_sel ? pair[3:0] : pair[7:4];
  end

  assign tile.io_out = (dbg == 3'b111) ? 8'hFF : {dig_sel, seg7(nib)};
endmodule

// File: tb/tb_hpretl_tt03_temp_sensor.sv
// Randomised bench for hpretl_tt03_temp_sensor: calibration words, CAL_ENA and DBG are
// varied and the display is compared against an arithmetic model of conversion and readout.
module tb_hpretl_tt03_temp_sensor;
`ifdef TEMPSENS_SIM_MODEL_EN
  localparam int SENS_DLY = 40;
`else
  localparam int SENS_DLY = 0;
`endif
  // sensor delay plus the two synchroniser cycles
  localparam int RAW_EXP = SENS_DLY + 2;

  logic       clk = 1'b0, rst_n = 1'b0, cal_clk = 1'b0, cal_dat = 1'b0, cal_ena = 1'b0;
  logic [2:0] dbg = 3'b000;

  hpretl_tt03_temp_sensor_if tile();
  assign tile.io_in = {dbg, cal_ena, cal_dat, cal_clk, rst_n, clk};

  hpretl_tt03_temp_sensor dut (.tile(tile));

  always #5 clk = ~clk;

  int edges = 0;
  always @(posedge clk) edges <= rst_n ? edges + 1 : 0;

  int          n_vec = 0, n_err = 0;
  logic [15:0] cal_m = 16'h0010;
  bit          meas = 1'b0;
  byte unsigned seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  function automatic logic [7:0] expect_out();
    int raw, off, gain, d, t, hi, lo;
    bit sel;
    sel  = ((edges / 4096) % 2) == 1;
    raw  = meas ? RAW_EXP : 0;
    off  = cal_ena ? int'(cal_m[15:6]) : 0;
    gain = cal_ena ? int'(cal_m[5:0]) : 16;
    d    = (raw > off) ? raw - off : 0;
    t    = (d * gain) / 16;
    if (t > 99) t = 99;
    case (dbg)
      3'b011:  begin hi = (raw / 16) % 16; lo = raw % 16; end
      3'b001:  begin hi = int'(cal_m[7:4]); lo = int'(cal_m[3:0]); end
      default: begin hi = t / 10; lo = t % 10; end
    endcase
    if (dbg == 3'b111) return 8'hFF;
    return sel ? {1'b1, seg_tab[lo][6:0]} : {1'b0, seg_tab[hi][6:0]};
  endfunction

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: io_out=%02h expected %02h (cycle %0d)", tag, got, exp, edges);
    end
  endtask

  task automatic cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic settle();
    cycles(200);
    meas = 1'b1;
  endtask

  task automatic check_both(input string tag);
    check_val({tag, "/first"}, tile.io_out, expect_out());
    cycles(4096);
    check_val({tag, "/second"}, tile.io_out, expect_out());
  endtask

  task automatic load_cal(input logic [15:0] v);
    for (int i = 15; i >= 0; i--) begin
      cal_dat = v[i];
      cal_clk = 1'b1;
      cycles(3);
      cal_clk = 1'b0;
      cycles(3);
    end
    cal_m = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cal_m = 16'h0010;
    meas  = 1'b0;
  endtask

  initial begin
    logic [15:0] v;
    do_reset();
    cycles(3);
    check_val("reset_hold", tile.io_out, 8'h3F);
    rst_n = 1'b1;
    cycles(1);
    check_val("post_reset", tile.io_out, 8'h3F);

    settle();
    check_both("temp_unity");
    dbg = 3'b011; cycles(1); check_both("raw_hex");
    dbg = 3'b001; cycles(1); check_both("cal_hex");
    dbg = 3'b111; cycles(1); check_val("lamp", tile.io_out, expect_out());
    dbg = 3'b101; cycles(1); check_val("dbg_unlisted", tile.io_out, expect_out());

    dbg = 3'b000;
    load_cal(16'b0000001010_100000); cal_ena = 1'b1; settle(); check_both("cal_off10_g32");
    load_cal({10'd50, 6'd16});                      settle(); check_both("cal_floor");
    load_cal({10'd0, 6'd63});                       settle(); check_both("cal_clamp");

    for (int k = 0; k < 5; k++) begin
      v = 16'($urandom);
      v[15:6] = 10'($urandom_range(0, 60));
      load_cal(v);
      cal_ena = 1'($urandom_range(0, 1));
      dbg     = 3'($urandom_range(0, 7));
      settle();
      check_both($sformatf("rand%0d", k));
    end

    // asynchronous clear while showing a live result, then abort a fresh measurement
    dbg = 3'b000; cal_ena = 1'b0;
    do_reset();
    #1 check_val("async_reset", tile.io_out, 8'h3F);
    cycles(2);
    rst_n = 1'b1;
    cycles(20);
    do_reset();
    #1 check_val("reset_mid_charge", tile.io_out, 8'h3F);
    cycles(2);
    rst_n = 1'b1;
    dbg = 3'b011;
    settle();
    check_both("raw_after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
